// File: rtl/prog_loader.sv
// Serial program loader: frames count/words/checksum bytes into 16-bit instruction-memory writes.
// Latency: each word is written in the cycle after its low byte is accepted; cpu_en rises the cycle after a good checksum.
// Backpressure: byte_ready is low in IDLE/WRITE/DONE/ERR; bytes offered then are simply not consumed.
module prog_loader #(
    parameter int          DEPTH     = 256,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_en,
    output logic        load_done,
    output logic        err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DAT_HI,
        S_DAT_LO,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] count;
    logic [15:0] index;
    logic [7:0]  checksum;
    logic [7:0]  hi_byte;
    logic        accept;
    logic [15:0] cnt_full;
    logic [15:0] index_inc;

    assign accept    = byte_valid && byte_ready;
    assign cnt_full  = {count[15:8], byte_data};
    assign index_inc = index + 16'd1;

    // State register; reset drops any load in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode of the frame: count, word pairs, checksum.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_CNT_HI;
            S_CNT_HI: if (accept) state_nxt = S_CNT_LO;
            S_CNT_LO: begin
                if (accept) begin
                    if (cnt_full == 16'd0)
                        state_nxt = S_CHK;
                    else if ({1'b0, cnt_full} > 17'(DEPTH))
                        state_nxt = S_ERR;
                    else
                        state_nxt = S_DAT_HI;
                end
            end
            S_DAT_HI: if (accept) state_nxt = S_DAT_LO;
            S_DAT_LO: if (accept) state_nxt = S_WRITE;
            S_WRITE:  state_nxt = (index_inc == count) ? S_CHK : S_DAT_HI;
            S_CHK: begin
                if (accept)
                    state_nxt = (byte_data == checksum) ? S_DONE : S_ERR;
            end
            S_DONE:   if (start) state_nxt = S_CNT_HI;
            S_ERR:    if (start) state_nxt = S_CNT_HI;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs decoded from the next state, so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            cpu_en     <= 1'b0;
            load_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            byte_ready <= (state_nxt == S_CNT_HI) || (state_nxt == S_CNT_LO) ||
                          (state_nxt == S_DAT_HI) || (state_nxt == S_DAT_LO) ||
                          (state_nxt == S_CHK);
            mem_we     <= (state_nxt == S_WRITE);
            cpu_en     <= (state_nxt == S_DONE);
            load_done  <= (state_nxt == S_DONE);
            err        <= (state_nxt == S_ERR);
        end
    end

    // Frame datapath: count capture, running checksum, word assembly and write address.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 16'd0;
            index     <= 16'd0;
            checksum  <= 8'd0;
            hi_byte   <= 8'd0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 16'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        checksum <= 8'd0;
                        index    <= 16'd0;
                    end
                end
                S_CNT_HI: begin
                    if (accept) begin
                        count[15:8] <= byte_data;
                        checksum    <= checksum ^ byte_data;
                    end
                end
                S_CNT_LO: begin
                    if (accept) begin
                        count[7:0] <= byte_data;
                        checksum   <= checksum ^ byte_data;
                    end
                end
                S_DAT_HI: begin
                    if (accept) begin
                        hi_byte  <= byte_data;
                        checksum <= checksum ^ byte_data;
                    end
                end
                S_DAT_LO: begin
                    if (accept) begin
                        checksum  <= checksum ^ byte_data;
                        mem_addr  <= BASE_ADDR + index;
                        mem_wdata <= {hi_byte, byte_data};
                    end
                end
                S_WRITE: index <= index_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed byte streams, expected writes queued by the stimulus and popped by a monitor.
// Latency: writes are checked whenever mem_we is seen; status is checked right after the relevant byte edge.
// Backpressure: the byte driver waits (bounded) for byte_ready before counting a byte as sent.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_en;
    logic        load_done;
    logic        err;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    prog_loader #(
        .DEPTH     (256),
        .BASE_ADDR (16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_en     (cpu_en),
        .load_done  (load_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every mem_we pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // {load_done, err, cpu_en, byte_ready}
    task automatic check_status(input string name, input logic [3:0] exp);
        logic [3:0] got;
        got = {load_done, err, cpu_en, byte_ready};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got done/err/cpu/rdy=%b, expected %b", name, got, exp);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected writes never seen, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit acc;
        bit done;
        done = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 40 && !done; t++) begin
            acc = byte_ready;
            @(negedge clk);
            if (acc) done = 1;
        end
        byte_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: byte %h not accepted, expected acceptance", b);
        end
        if (gap) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Two-word frame 00 02 12 34 AB CD <chk>.
    task automatic two_word_stream(input bit gap, input logic [7:0] chk);
        send_byte(8'h00, gap);
        send_byte(8'h02, gap);
        send_byte(8'h12, gap);
        exp_q.push_back('{addr: 16'h0000, data: 16'h1234});
        send_byte(8'h34, gap);
        send_byte(8'hAB, gap);
        exp_q.push_back('{addr: 16'h0001, data: 16'hABCD});
        send_byte(8'hCD, gap);
        send_byte(chk, gap);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        // Reset with noisy inputs
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            byte_valid = 1'($urandom_range(0, 1));
            start      = 1'($urandom_range(0, 1));
            byte_data  = 8'($urandom_range(0, 255));
            check_status("reset_outputs", 4'b0000);
            checks++;
            if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin
                errors++;
                $display("FAIL reset_addr: got addr=%h data=%h, expected 0000/0000", mem_addr, mem_wdata);
            end
        end
        rst        = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        check_status("idle_after_reset", 4'b0000);

        // Good load
        pulse_start();
        check_status("cnt_hi_ready", 4'b0001);
        two_word_stream(1'b0, 8'h42);
        check_status("good_done", 4'b1010);
        check_drained("good_writes");

        // Bad checksum, then recovery
        pulse_start();
        check_status("start_from_done", 4'b0001);
        two_word_stream(1'b0, 8'h43);
        check_status("bad_chk_err", 4'b0100);
        check_drained("bad_chk_writes");
        pulse_start();
        check_status("start_from_err", 4'b0001);
        two_word_stream(1'b0, 8'h42);
        check_status("reload_done", 4'b1010);
        check_drained("reload_writes");

        // Empty load
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check_status("empty_done", 4'b1010);

        // Oversize count 0x0101 > 256
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        check_status("oversize_err", 4'b0100);
        repeat (3) @(negedge clk);
        check_status("oversize_hold", 4'b0100);

        // Gapped stream
        pulse_start();
        two_word_stream(1'b1, 8'h42);
        check_status("gapped_done", 4'b1010);
        check_drained("gapped_writes");

        // Reset in DAT_LO after the first word
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        exp_q.push_back('{addr: 16'h0000, data: 16'h1234});
        send_byte(8'h34, 1'b0);
        send_byte(8'hAB, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_status("midload_reset", 4'b0000);
        byte_valid = 1'b1;
        byte_data  = 8'hCD;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        check_status("after_reset_idle", 4'b0000);
        check_drained("midload_writes");

        // Start ignored while in DAT_HI
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        exp_q.push_back('{addr: 16'h0000, data: 16'h1234});
        send_byte(8'h34, 1'b0);
        @(negedge clk);
        pulse_start();
        check_status("start_ignored", 4'b0001);
        send_byte(8'hAB, 1'b0);
        exp_q.push_back('{addr: 16'h0001, data: 16'hABCD});
        send_byte(8'hCD, 1'b0);
        send_byte(8'h42, 1'b0);
        check_status("ignored_start_done", 4'b1010);

        repeat (3) @(negedge clk);
        check_drained("final_writes");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
